tone_decoder: RTL and testbench

TONE_DECODER -- requirements
Module: tone_decoder

---
 rtl/tone_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_tone_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
// -----------------------------------------------------------------------------
// tone_decoder
//
// Recognises a square-wave audio tone by measuring its half-period and looking
// the result up in a 21-entry note table (three octaves of C..B). A note is
// only reported once two consecutive half-period measurements agree, so a
// single glitchy interval never changes the outputs. A long gap with no input
// edges is treated as silence and clears the reported note.
//
// Ports
//   sys_clk      in   system clock, the only clock
//   sys_rst      in   synchronous active-high reset
//   init_done    in   when low, the FSM and all counters hold their values
//   tone_in      in   asynchronous square-wave audio input
//   note_valid   out  a recognised note is present
//   scale        out  octave: 0 low, 1 mid, 2 high
//   key          out  note 1..7 (C..B), 0 = none
//   half_period  out  last measured half-period, in ticks
//   note_change  out  one-cycle pulse after any change of {note_valid,scale,key}
// -----------------------------------------------------------------------------
module tone_decoder #(
  parameter int CLK_DIV       = 1000,
  parameter int TOL           = 1,
  parameter int SILENCE_TICKS = 255
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       init_done,
  input  logic       tone_in,
  output logic       note_valid,
  output logic [1:0] scale,
  output logic [3:0] key,
  output logic [7:0] half_period,
  output logic       note_change
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       SIL_LIM  = 8'(SILENCE_TICKS);
  localparam logic [8:0]       TOL_9    = 9'(TOL);

  localparam logic [1:0] ST_WAIT_EDGE = 2'd0;
  localparam logic [1:0] ST_MEASURE   = 2'd1;
  localparam logic [1:0] ST_SEARCH    = 2'd2;
  localparam logic [1:0] ST_DECIDE    = 2'd3;

  // Candidate encoding {valid, scale[1:0], key[3:0]}; all-zero means "none".
  localparam logic [6:0] CAND_NONE = 7'd0;

  // Half-period table in ticks; entry 0 sits in the least significant byte.
  localparam logic [8*21-1:0] HP_TABLE = {
    8'd25,  8'd28,  8'd32,  8'd36,  8'd38,  8'd43,  8'd48,   // high
    8'd51,  8'd57,  8'd64,  8'd72,  8'd76,  8'd85,  8'd96,   // mid
    8'd101, 8'd114, 8'd128, 8'd143, 8'd152, 8'd170, 8'd191   // low
  };

  // Padded to the full 5-bit index range so any idx value addresses a real entry.
  logic [7:0] table_rom [0:31];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rom
      if (gi < 21) begin : g_entry
        assign table_rom[gi] = HP_TABLE[gi*8 +: 8];
      end else begin : g_pad
        assign table_rom[gi] = 8'd0;
      end
    end
  endgenerate

  logic             sync1_reg, sync2_reg, sync3_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [7:0]       hp_cnt_reg;
  logic [1:0]       state_reg;
  logic [7:0]       meas_reg;
  logic [4:0]       idx_reg;
  logic [1:0]       srch_scale_reg;
  logic [3:0]       srch_key_reg;
  logic [6:0]       cand_reg;
  logic [6:0]       prev_cand_reg;
  logic             note_valid_reg;
  logic [1:0]       scale_reg;
  logic [3:0]       key_reg;
  logic [7:0]       half_period_reg;
  logic             note_change_reg;
  logic [6:0]       out_prev_reg;

  logic       edge_det;
  logic       tick;
  logic       silence;
  logic [7:0] tbl_val;
  logic [8:0] diff_9;
  logic       hit;

  // sync3 is the previous synchronised level; any difference is an edge.
  assign edge_det = sync2_reg ^ sync3_reg;
  assign tick     = (div_cnt_reg == DIV_LAST);
  assign silence  = (hp_cnt_reg >= SIL_LIM);
  assign tbl_val  = table_rom[idx_reg];

  // Absolute difference at 9 bits so neither subtraction direction can wrap.
  always_comb begin
    diff_9 = 9'd0;
    if (meas_reg >= tbl_val) begin
      diff_9 = {1'b0, meas_reg} - {1'b0, tbl_val};
    end else begin
      diff_9 = {1'b0, tbl_val} - {1'b0, meas_reg};
    end
  end

  assign hit = (diff_9 <= TOL_9);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      sync3_reg       <= 1'b0;
      div_cnt_reg     <= '0;
      hp_cnt_reg      <= 8'd0;
      state_reg       <= ST_WAIT_EDGE;
      meas_reg        <= 8'd0;
      idx_reg         <= 5'd0;
      srch_scale_reg  <= 2'd0;
      srch_key_reg    <= 4'd1;
      cand_reg        <= CAND_NONE;
      prev_cand_reg   <= CAND_NONE;
      note_valid_reg  <= 1'b0;
      scale_reg       <= 2'd1;
      key_reg         <= 4'd0;
      half_period_reg <= 8'd0;
      note_change_reg <= 1'b0;
      out_prev_reg    <= {1'b0, 2'd1, 4'd0};
    end else begin
      sync1_reg <= tone_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;

      // Compare against last cycle's fields: the pulse lands one cycle after a change.
      out_prev_reg    <= {note_valid_reg, scale_reg, key_reg};
      note_change_reg <= ({note_valid_reg, scale_reg, key_reg} != out_prev_reg);

      if (init_done) begin
        div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;

        // Edges clear the interval counter regardless of FSM state.
        if (edge_det) begin
          hp_cnt_reg <= 8'd0;
        end else if (tick && (hp_cnt_reg != 8'd255)) begin
          hp_cnt_reg <= hp_cnt_reg + 8'd1;
        end

        case (state_reg)
          ST_WAIT_EDGE: begin
            // The interval before the first edge has no known start, so it is dropped.
            if (edge_det) begin
              state_reg <= ST_MEASURE;
            end else if (silence) begin
              note_valid_reg <= 1'b0;
              key_reg        <= 4'd0;
              prev_cand_reg  <= CAND_NONE;
            end
          end

          ST_MEASURE: begin
            if (edge_det) begin
              meas_reg        <= hp_cnt_reg;
              half_period_reg <= hp_cnt_reg;
              idx_reg         <= 5'd0;
              srch_scale_reg  <= 2'd0;
              srch_key_reg    <= 4'd1;
              state_reg       <= ST_SEARCH;
            end else if (silence) begin
              note_valid_reg <= 1'b0;
              key_reg        <= 4'd0;
              prev_cand_reg  <= CAND_NONE;
              state_reg      <= ST_WAIT_EDGE;
            end
          end

          ST_SEARCH: begin
            // Linear scan from idx 0 so the lowest matching entry always wins.
            if (hit) begin
              cand_reg  <= {1'b1, srch_scale_reg, srch_key_reg};
              state_reg <= ST_DECIDE;
            end else if (idx_reg == 5'd20) begin
              cand_reg  <= CAND_NONE;
              state_reg <= ST_DECIDE;
            end else begin
              idx_reg <= idx_reg + 5'd1;
              // scale/key track idx so no divide-by-7 is needed.
              if (srch_key_reg == 4'd7) begin
                srch_key_reg   <= 4'd1;
                srch_scale_reg <= srch_scale_reg + 2'd1;
              end else begin
                srch_key_reg <= srch_key_reg + 4'd1;
              end
            end
          end

          ST_DECIDE: begin
            // Two consecutive agreeing intervals are required before outputs move.
            if (cand_reg == prev_cand_reg) begin
              if (cand_reg[6]) begin
                note_valid_reg <= 1'b1;
                scale_reg      <= cand_reg[5:4];
                key_reg        <= cand_reg[3:0];
              end else begin
                note_valid_reg <= 1'b0;
                key_reg        <= 4'd0;
              end
            end
            prev_cand_reg <= cand_reg;
            state_reg     <= ST_MEASURE;
          end

          default: state_reg <= ST_WAIT_EDGE;
        endcase
      end
    end
  end

  assign note_valid  = note_valid_reg;
  assign scale       = scale_reg;
  assign key         = key_reg;
  assign half_period = half_period_reg;
  assign note_change = note_change_reg;

endmodule

// File: tb/tb_tone_decoder.sv
// -----------------------------------------------------------------------------
// tb_tone_decoder
//
// Drives tone_decoder with directed and random square waves. Every toggle is fed
// to an interval-level reference model that pushes each expected output change
// into a queue; a monitor pops one entry per note_change pulse and compares.
// CLK_DIV is shrunk to 4 so whole-note scenarios fit in a short run.
// -----------------------------------------------------------------------------
module tb_tone_decoder;

  localparam int D   = 4;
  localparam int TOL = 1;
  localparam int SIL = 255;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       init_done;
  logic       tone_in;
  logic       note_valid;
  logic [1:0] scale;
  logic [3:0] key;
  logic [7:0] half_period;
  logic       note_change;

  always #5 sys_clk = ~sys_clk;

  tone_decoder #(
    .CLK_DIV       (D),
    .TOL           (TOL),
    .SILENCE_TICKS (SIL)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .init_done   (init_done),
    .tone_in     (tone_in),
    .note_valid  (note_valid),
    .scale       (scale),
    .key         (key),
    .half_period (half_period),
    .note_change (note_change)
  );

  typedef struct {
    int nv;
    int sc;
    int ky;
    int hp_lo;
    int hp_hi;
    int t_push;
    int max_lat;
  } exp_t;

  exp_t exp_q[$];

  int tbl[21] = '{191, 170, 152, 143, 128, 114, 101,
                  96, 85, 76, 72, 64, 57, 51,
                  48, 43, 38, 36, 32, 28, 25};

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit chk_req = 1'b0;
  bit fin_req = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Reference model state, one step per edge interval.
  int m_nv = 0, m_sc = 1, m_ky = 0, m_prev = -1, m_hp_lo = 0, m_hp_hi = 0;
  bit m_armed = 1'b0;

  function automatic int match_idx(input int m);
    for (int i = 0; i < 21; i++) begin
      if (((m > tbl[i]) ? (m - tbl[i]) : (tbl[i] - m)) <= TOL) return i;
    end
    return -1;
  endfunction

  task automatic model_set(input int nv, input int sc, input int ky, input int lat);
    exp_t e;
    if (nv != m_nv || sc != m_sc || ky != m_ky) begin
      e.nv = nv; e.sc = sc; e.ky = ky;
      e.hp_lo = m_hp_lo; e.hp_hi = m_hp_hi;
      e.t_push = cyc; e.max_lat = lat;
      exp_q.push_back(e);
      m_nv = nv; m_sc = sc; m_ky = ky;
    end
  endtask

  // n*D clocks between edges yields n or n-1 ticks depending on tick phase.
  task automatic model_edge(input int n);
    int c;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      c = match_idx(n);
      m_hp_lo = n - 1;
      m_hp_hi = n;
      if (c == m_prev) begin
        if (c >= 0) model_set(1, c / 7, c % 7 + 1, 30);
        else        model_set(0, m_sc, 0, 30);
      end
      m_prev = c;
    end
  endtask

  task automatic model_reset();
    m_nv = 0; m_sc = 1; m_ky = 0; m_prev = -1;
    m_hp_lo = 0; m_hp_hi = 0; m_armed = 1'b0;
  endtask

  task automatic send_edge(input int n);
    repeat (n * D) @(negedge sys_clk);
    tone_in = ~tone_in;
    model_edge(n);
  endtask

  task automatic do_silence();
    model_set(0, m_sc, 0, 270 * D + 10);
    m_prev  = -1;
    m_armed = 1'b0;
    repeat (270 * D) @(negedge sys_clk);
  endtask

  task automatic request_reset_check();
    @(posedge sys_clk);
    chk_req = 1'b1;
    @(posedge sys_clk);
    chk_req = 1'b0;
  endtask

  function automatic void cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Sole owner of the check counters.
  always @(negedge sys_clk) begin
    exp_t e;
    if (chk_req) begin
      cmp("reset_note_valid", int'(note_valid), 0);
      cmp("reset_scale", int'(scale), 1);
      cmp("reset_key", int'(key), 0);
      cmp("reset_half_period", int'(half_period), 0);
      cmp("reset_note_change", int'(note_change), 0);
      $display("check reset values at cycle %0d", cyc);
    end
    if (fin_req) begin
      cmp("pending_changes", exp_q.size(), 0);
    end
    if (note_change) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_note_change: got nv=%0d scale=%0d key=%0d, want no pulse (cycle %0d)",
                 note_valid, scale, key, cyc);
      end else begin
        e = exp_q.pop_front();
        cmp("note_valid", int'(note_valid), e.nv);
        cmp("scale", int'(scale), e.sc);
        cmp("key", int'(key), e.ky);
        checks++;
        if (int'(half_period) < e.hp_lo || int'(half_period) > e.hp_hi) begin
          fails++;
          $display("FAIL half_period: got %0d, want %0d..%0d (cycle %0d)",
                   half_period, e.hp_lo, e.hp_hi, cyc);
        end
        checks++;
        if (cyc - e.t_push > e.max_lat) begin
          fails++;
          $display("FAIL latency: got %0d cycles, want <= %0d", cyc - e.t_push, e.max_lat);
        end
        $display("change at cycle %0d: nv=%0d scale=%0d key=%0d half_period=%0d",
                 cyc, note_valid, scale, key, half_period);
      end
    end
  end

  initial begin
    int n;
    int k;
    sys_rst   = 1'b1;
    init_done = 1'b0;
    tone_in   = 1'b0;

    // Reset held while the input toggles; no pulse may escape.
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      tone_in = ~tone_in;
    end
    tone_in = 1'b0;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    init_done = 1'b1;
    request_reset_check();

    // 880 Hz -> mid A, then 1046.5 Hz -> high C, then an unmatched 150 ticks.
    repeat (4) send_edge(57);
    repeat (3) send_edge(48);
    repeat (3) send_edge(150);

    // 440 Hz -> low A, then silence.
    repeat (3) send_edge(114);
    do_silence();

    // Reset during SEARCH: the pending update must be dropped.
    send_edge(28);
    send_edge(28);
    repeat (28 * D) @(negedge sys_clk);
    tone_in = ~tone_in;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b1;
    tone_in = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    repeat (40) @(negedge sys_clk);
    request_reset_check();
    repeat (4) send_edge(114);

    // Random tones; periods chosen so both possible tick counts classify alike.
    for (int seg = 0; seg < 18; seg++) begin
      do begin
        n = $urandom_range(22, 200);
      end while (match_idx(n - 1) != match_idx(n));
      k = $urandom_range(2, 4);
      repeat (k) send_edge(n);
      if ($urandom_range(0, 5) == 0) do_silence();
    end

    repeat (100) @(negedge sys_clk);
    @(posedge sys_clk);
    fin_req = 1'b1;
    @(posedge sys_clk);
    fin_req = 1'b0;
    @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
